// File: rtl/sq_slot_sched.sv
// Time-multiplexed operator scheduler: walks 2**SLOT_W slots per sample tick through a shared sine/pow datapath.
// Define SQ_SCHED_MIX_EN to add a per-frame sum of all slot results (mix_out/mix_valid).
module sq_slot_sched #(
  parameter int SLOT_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              cfg_we,
  input  logic [SLOT_W-1:0] cfg_slot,
  input  logic [10:0]       cfg_fnumber,
  input  logic [2:0]        cfg_block,
  input  logic [3:0]        cfg_multiple,
  input  logic              cfg_key,
  output logic [9:0]        phase_out,
  input  logic [12:0]       sin_val,
  output logic              pow_req,
  output logic [12:0]       pow_x,
  input  logic              pow_ack,
  input  logic [12:0]       pow_y,
  output logic [12:0]       slot_out,
  output logic [SLOT_W-1:0] slot_idx,
  output logic              slot_valid,
  output logic              frame_done,
`ifdef SQ_SCHED_MIX_EN
  output logic [13+SLOT_W-1:0] mix_out,
  output logic              mix_valid,
`endif
  output logic              overrun
);

  localparam int SLOTS = 1 << SLOT_W;
  localparam int MIX_W = 13 + SLOT_W;

  typedef enum logic [2:0] {S_IDLE, S_ACC, S_LOOK, S_CAP, S_POW, S_DONE} state_t;

  logic [10:0] fnum_q [SLOTS];
  logic [2:0]  blk_q  [SLOTS];
  logic [3:0]  mul_q  [SLOTS];
  logic [19:0] acc_q  [SLOTS];
  logic [SLOTS-1:0] key_q;

  state_t            state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [9:0]        phase_q, phase_d;
  logic              pow_req_q, pow_req_d;
  logic [12:0]       pow_x_q, pow_x_d;
  logic [12:0]       slot_out_q, slot_out_d;
  logic [SLOT_W-1:0] slot_idx_q, slot_idx_d;
  logic              slot_valid_q, slot_valid_d;
  logic              frame_done_q, frame_done_d;
  logic              overrun_q, overrun_d;
  logic              acc_we_s;
  logic              last_slot_s;
  logic [SLOT_W-1:0] next_slot_s;
  logic [19:0]       inc_s, acc_sum_s;
`ifdef SQ_SCHED_MIX_EN
  logic [MIX_W-1:0]  mix_acc_q, mix_acc_d, mix_out_q, mix_out_d;
  logic              mix_valid_q, mix_valid_d;
`endif

  // multiple==0 means x0.5; otherwise integer multiply, truncated to the 20-bit accumulator width
  function automatic logic [19:0] calc_inc(input logic [10:0] fn, input logic [2:0] blk,
                                           input logic [3:0] mul);
    logic [19:0] fmult;
    logic [23:0] prod;
    fmult = {9'b0, fn} << blk;
    prod  = {4'b0, fmult} * {20'b0, mul};
    return (mul == 4'd0) ? (fmult >> 1) : prod[19:0];
  endfunction

  assign inc_s       = calc_inc(fnum_q[slot_q], blk_q[slot_q], mul_q[slot_q]);
  assign acc_sum_s   = acc_q[slot_q] + inc_s;
  assign last_slot_s = (slot_q == SLOT_W'(SLOTS - 1));
  assign next_slot_s = last_slot_s ? {SLOT_W{1'b0}} : slot_q + SLOT_W'(1);

  // Per-slot config and phase accumulators; a key-off write clears the accumulator
  always_ff @(posedge clk) begin
    if (reset) begin
      key_q <= {SLOTS{1'b0}};
      for (int i = 0; i < SLOTS; i++) begin
        fnum_q[i] <= 11'd0;
        blk_q[i]  <= 3'd0;
        mul_q[i]  <= 4'd0;
        acc_q[i]  <= 20'd0;
      end
    end else begin
      for (int i = 0; i < SLOTS; i++) begin
        if (cfg_we && cfg_slot == SLOT_W'(i)) begin
          fnum_q[i] <= cfg_fnumber;
          blk_q[i]  <= cfg_block;
          mul_q[i]  <= cfg_multiple;
          key_q[i]  <= cfg_key;
        end
        if (cfg_we && cfg_slot == SLOT_W'(i) && !cfg_key) begin
          acc_q[i] <= 20'd0;
        end else if (acc_we_s && slot_q == SLOT_W'(i)) begin
          acc_q[i] <= acc_sum_s;
        end else begin
          acc_q[i] <= acc_q[i];
        end
      end
    end
  end

  // FSM state and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      slot_q       <= {SLOT_W{1'b0}};
      phase_q      <= 10'd0;
      pow_req_q    <= 1'b0;
      pow_x_q      <= 13'd0;
      slot_out_q   <= 13'd0;
      slot_idx_q   <= {SLOT_W{1'b0}};
      slot_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef SQ_SCHED_MIX_EN
      mix_acc_q    <= {MIX_W{1'b0}};
      mix_out_q    <= {MIX_W{1'b0}};
      mix_valid_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      phase_q      <= phase_d;
      pow_req_q    <= pow_req_d;
      pow_x_q      <= pow_x_d;
      slot_out_q   <= slot_out_d;
      slot_idx_q   <= slot_idx_d;
      slot_valid_q <= slot_valid_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
`ifdef SQ_SCHED_MIX_EN
      mix_acc_q    <= mix_acc_d;
      mix_out_q    <= mix_out_d;
      mix_valid_q  <= mix_valid_d;
`endif
    end
  end

  // Next-state and output logic; the frame stays busy through the frame_done cycle
  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    phase_d      = phase_q;
    pow_req_d    = pow_req_q;
    pow_x_d      = pow_x_q;
    slot_out_d   = slot_out_q;
    slot_idx_d   = slot_idx_q;
    slot_valid_d = 1'b0;
    frame_done_d = 1'b0;
    acc_we_s     = 1'b0;
`ifdef SQ_SCHED_MIX_EN
    mix_acc_d    = mix_acc_q;
    mix_out_d    = mix_out_q;
    mix_valid_d  = 1'b0;
`endif
    if (tick && (state_q != S_IDLE || frame_done_q)) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_q;
    end
    case (state_q)
      S_IDLE: begin
        if (tick && !frame_done_q) begin
          state_d = S_ACC;
          slot_d  = {SLOT_W{1'b0}};
`ifdef SQ_SCHED_MIX_EN
          mix_acc_d = {MIX_W{1'b0}};
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACC: begin
        if (key_q[slot_q]) begin
          acc_we_s = 1'b1;
          phase_d  = acc_sum_s[19:10];
          state_d  = S_LOOK;
        end else begin
          slot_out_d   = 13'd0;
          slot_idx_d   = slot_q;
          slot_valid_d = 1'b1;
          slot_d       = next_slot_s;
          state_d      = last_slot_s ? S_DONE : S_ACC;
        end
      end
      S_LOOK: state_d = S_CAP;
      S_CAP: begin
        pow_x_d   = sin_val;
        pow_req_d = 1'b1;
        state_d   = S_POW;
      end
      S_POW: begin
        if (pow_ack) begin
          pow_req_d    = 1'b0;
          slot_out_d   = pow_y;
          slot_idx_d   = slot_q;
          slot_valid_d = 1'b1;
          slot_d       = next_slot_s;
          state_d      = last_slot_s ? S_DONE : S_ACC;
`ifdef SQ_SCHED_MIX_EN
          mix_acc_d = mix_acc_q + {{SLOT_W{pow_y[12]}}, pow_y};
`endif
        end else begin
          pow_req_d = 1'b1;
        end
      end
      S_DONE: begin
        frame_done_d = 1'b1;
        state_d      = S_IDLE;
`ifdef SQ_SCHED_MIX_EN
        mix_out_d   = mix_acc_q;
        mix_valid_d = 1'b1;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign phase_out  = phase_q;
  assign pow_req    = pow_req_q;
  assign pow_x      = pow_x_q;
  assign slot_out   = slot_out_q;
  assign slot_idx   = slot_idx_q;
  assign slot_valid = slot_valid_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;
`ifdef SQ_SCHED_MIX_EN
  assign mix_out    = mix_out_q;
  assign mix_valid  = mix_valid_q;
`endif

endmodule

// File: tb/tb_sq_slot_sched.sv
// Self-checking bench for sq_slot_sched: increment table, scoreboarded slot results, overrun and reset corners.
// Models a registered sine table and a pow unit with configurable ack delay.
module tb_sq_slot_sched;
  localparam int SLOT_W = 2;
  localparam int SLOTS  = 4;

  logic clk, reset, tick, cfg_we, cfg_key, pow_req, pow_ack, slot_valid, frame_done, overrun;
  logic [SLOT_W-1:0] cfg_slot, slot_idx;
  logic [10:0] cfg_fnumber;
  logic [2:0]  cfg_block;
  logic [3:0]  cfg_multiple;
  logic [9:0]  phase_out;
  logic [12:0] sin_val, pow_x, pow_y, slot_out;
`ifdef SQ_SCHED_MIX_EN
  logic [14:0] mix_out;
  logic        mix_valid;
`endif

  sq_slot_sched #(.SLOT_W(SLOT_W)) dut (
    .clk(clk), .reset(reset), .tick(tick), .cfg_we(cfg_we), .cfg_slot(cfg_slot),
    .cfg_fnumber(cfg_fnumber), .cfg_block(cfg_block), .cfg_multiple(cfg_multiple),
    .cfg_key(cfg_key), .phase_out(phase_out), .sin_val(sin_val), .pow_req(pow_req),
    .pow_x(pow_x), .pow_ack(pow_ack), .pow_y(pow_y), .slot_out(slot_out),
    .slot_idx(slot_idx), .slot_valid(slot_valid), .frame_done(frame_done),
`ifdef SQ_SCHED_MIX_EN
    .mix_out(mix_out), .mix_valid(mix_valid),
`endif
    .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int pow_delay = 0;
  int tick_cyc = 0;
  int last_cyc = 0;
  int exp_mix = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference model
  logic [10:0] m_fn [SLOTS];
  logic [2:0]  m_blk[SLOTS];
  logic [3:0]  m_mul[SLOTS];
  bit          m_key[SLOTS];
  int unsigned m_acc[SLOTS];

  typedef struct { int idx; logic [12:0] out; logic [12:0] px; bit act; } exp_t;
  exp_t sb[$];
  logic [12:0] force_vals[$];

  function automatic int unsigned model_inc(int unsigned fn, int unsigned blk, int unsigned mul);
    int unsigned f = fn << blk;
    if (mul == 0) return f >> 1;
    return (f * mul) & 32'h000F_FFFF;
  endfunction

  function automatic logic [12:0] sinf(input logic [9:0] p);
    return ({3'b000, p} * 13'd37) ^ {p, 3'b011};
  endfunction

  function automatic logic [12:0] powf(input logic [12:0] x);
    return (x * 13'd3) ^ 13'h00A5;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < SLOTS; s++) begin
      m_fn[s] = 11'd0; m_blk[s] = 3'd0; m_mul[s] = 4'd0; m_key[s] = 1'b0; m_acc[s] = 0;
    end
    sb.delete();
  endtask

  task automatic model_frame();
    exp_mix = 0;
    for (int s = 0; s < SLOTS; s++) begin
      exp_t e;
      e.idx = s;
      e.act = m_key[s];
      e.px  = 13'd0;
      e.out = 13'd0;
      if (m_key[s]) begin
        m_acc[s] = (m_acc[s] + model_inc(m_fn[s], m_blk[s], m_mul[s])) & 32'h000F_FFFF;
        e.px  = sinf(10'(m_acc[s] >> 10));
        e.out = (force_vals.size() > 0) ? force_vals.pop_front() : powf(e.px);
      end
      exp_mix = exp_mix + int'($signed(e.out));
      sb.push_back(e);
    end
  endtask

  task automatic cfg_wr(input int s, input logic [10:0] fn, input logic [2:0] blk,
                        input logic [3:0] mul, input logic key);
    @(negedge clk);
    cfg_we = 1'b1; cfg_slot = SLOT_W'(s); cfg_fnumber = fn; cfg_block = blk;
    cfg_multiple = mul; cfg_key = key;
    m_fn[s] = fn; m_blk[s] = blk; m_mul[s] = mul; m_key[s] = key;
    if (!key) m_acc[s] = 0;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic start_frame();
    @(negedge clk);
    tick = 1'b1;
    tick_cyc = cyc;
    model_frame();
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic wait_frame();
    int n = 0;
    while (!frame_done && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!frame_done) chk("frame_done_timeout", frame_done, 1);
  endtask

  task automatic wait_pow_req(input int remaining);
    int n = 0;
    while (!(pow_req && sb.size() == remaining) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!pow_req) chk("pow_req_timeout", pow_req, 1);
  endtask

  // registered sine table: one cycle from phase_out to sin_val
  initial begin
    sin_val = 13'd0;
    forever begin
      logic [9:0] p;
      @(negedge clk);
      p = phase_out;
      @(posedge clk);
      #1 sin_val = sinf(p);
    end
  end

  // pow unit: acks after pow_delay cycles with the scoreboard's expected result
  initial begin
    pow_ack = 1'b0;
    pow_y   = 13'd0;
    forever begin
      @(negedge clk);
      if (pow_req) begin
        repeat (pow_delay) @(negedge clk);
        if (sb.size() > 0 && pow_req) begin
          chk("pow_x", pow_x, sb[0].px);
          pow_y = sb[0].out;
        end else begin
          pow_y = 13'($urandom);
        end
        pow_ack = 1'b1;
        @(negedge clk);
        pow_ack = 1'b0;
      end
    end
  end

  // output monitor
  initial begin
    forever begin
      @(negedge clk);
      if (slot_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_slot_valid", slot_valid, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("slot_idx", slot_idx, e.idx);
          chk("slot_out", slot_out, e.out);
          if (e.idx == 0 && pow_delay == 0) chk("slot0_latency", cyc - tick_cyc, e.act ? 5 : 2);
          if (slot_idx == SLOT_W'(SLOTS - 1)) last_cyc = cyc;
        end
      end
      if (frame_done) begin
        chk("frame_done_gap", cyc - last_cyc, 1);
`ifdef SQ_SCHED_MIX_EN
        chk("mix_valid", mix_valid, 1);
        chk("mix_out", mix_out, 32'(exp_mix) & 32'h7FFF);
`endif
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  typedef struct { logic [10:0] fn; logic [2:0] blk; logic [3:0] mul; logic [19:0] inc; } vec_t;
  vec_t vt[7];

  initial begin
    reset = 1'b1; tick = 1'b0; cfg_we = 1'b0; cfg_slot = '0; cfg_fnumber = 11'd0;
    cfg_block = 3'd0; cfg_multiple = 4'd0; cfg_key = 1'b0;
    model_reset();
    vt[0] = '{11'h200, 3'd0, 4'd1,  20'h00200};
    vt[1] = '{11'h200, 3'd0, 4'd0,  20'h00100};
    vt[2] = '{11'h7FF, 3'd7, 4'd15, 20'hBF880};
    vt[3] = '{11'h155, 3'd3, 4'd5,  20'h03548};
    vt[4] = '{11'h7FF, 3'd7, 4'd0,  20'h1FFC0};
    vt[5] = '{11'h001, 3'd7, 4'd2,  20'h00100};
    vt[6] = '{11'h400, 3'd7, 4'd8,  20'h00000};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_phase_out", phase_out, 0);
    chk("rst_pow_req", pow_req, 0);
    chk("rst_pow_x", pow_x, 0);
    chk("rst_slot_out", slot_out, 0);
    chk("rst_slot_idx", slot_idx, 0);
    chk("rst_slot_valid", slot_valid, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_overrun", overrun, 0);
`ifdef SQ_SCHED_MIX_EN
    chk("rst_mix_out", mix_out, 0);
    chk("rst_mix_valid", mix_valid, 0);
`endif
    reset = 1'b0;

    // increment table: slot 0 only, phase after 1..3 frames
    pow_delay = 0;
    for (int i = 0; i < 7; i++) begin
      cfg_wr(0, 11'd0, 3'd0, 4'd0, 1'b0);
      cfg_wr(0, vt[i].fn, vt[i].blk, vt[i].mul, 1'b1);
      for (int k = 1; k <= 3; k++) begin
        start_frame();
        wait_frame();
        chk($sformatf("phase_row%0d_f%0d", i, k), phase_out,
            ((k * int'(vt[i].inc)) & 32'h000F_FFFF) >> 10);
      end
    end

    // all four slots active, slow pow unit
    pow_delay = 3;
    cfg_wr(0, 11'h200, 3'd0, 4'd1, 1'b1);
    cfg_wr(1, 11'h200, 3'd0, 4'd0, 1'b1);
    cfg_wr(2, 11'h7FF, 3'd7, 4'd15, 1'b1);
    cfg_wr(3, 11'h0AB, 3'd2, 4'd3, 1'b1);
    start_frame();
    wait_frame();
    chk("frame4_drained", sb.size(), 0);

    // tick during slot 2's pow wait: ignored, overrun sticks
    start_frame();
    wait_pow_req(2);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    chk("overrun_set", overrun, 1);
    wait_frame();
    chk("overrun_frame_drained", sb.size(), 0);
    start_frame();
    wait_frame();
    chk("overrun_sticky", overrun, 1);

    // reset while waiting on pow
    start_frame();
    wait_pow_req(4);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    chk("mid_rst_pow_req", pow_req, 0);
    chk("mid_rst_phase_out", phase_out, 0);
    chk("mid_rst_pow_x", pow_x, 0);
    chk("mid_rst_slot_out", slot_out, 0);
    chk("mid_rst_overrun", overrun, 0);
    repeat (8) @(negedge clk);
    cfg_wr(0, 11'h123, 3'd1, 4'd2, 1'b1);
    start_frame();
    wait_frame();
    chk("post_rst_drained", sb.size(), 0);

    // tick in the frame_done cycle is an overrun, no frame starts
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    chk("done_cycle_overrun", overrun, 1);
    repeat (6) @(negedge clk);
    chk("done_cycle_no_start", pow_req, 0);
    start_frame();
    wait_frame();
    chk("after_done_drained", sb.size(), 0);

`ifdef SQ_SCHED_MIX_EN
    cfg_wr(1, 11'h050, 3'd1, 4'd1, 1'b1);
    cfg_wr(2, 11'h000, 3'd0, 4'd0, 1'b0);
    cfg_wr(3, 11'h0AB, 3'd2, 4'd3, 1'b1);
    force_vals.push_back(13'd100);
    force_vals.push_back(13'h1FCE);
    force_vals.push_back(13'd7);
    start_frame();
    wait_frame();
    chk("mix57_valid", mix_valid, 1);
    chk("mix57_value", mix_out, 57);
`endif

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
